fp_recip_seq: RTL and testbench

//   Newton-Raphson reciprocal sequencer for the iterative divide path. Takes a

---
 rtl/fp_recip_seq.sv | 135 +++++++++++++
 tb/tb_fp_recip_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp_recip_seq.sv
// Newton-Raphson reciprocal sequencer driving an external combinational MAC.
// Result after 2+2*ITER cycles; start is taken only while ready, never queued.
module fp_recip_seq #(
  parameter int ITER = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] m,
  input  logic        kill,
  output logic        ready,
  output logic [26:0] mac_a,
  output logic [26:0] mac_b,
  output logic [26:0] mac_c,
  output logic        mac_op,
  input  logic [51:0] mac_d,
  output logic        valid,
  output logic [26:0] recip,
  output logic        rem_neg,
  output logic        inv
);

  localparam logic [26:0] ONE = 27'h2000000;

  typedef enum logic [2:0] {IDLE, ERR, UPD, CORR, DONE} state_t;

  state_t      state, state_nxt;
  logic [26:0] mq, y, e, y0, mac_nar;
  logic [2:0]  count, cnt_inc;
  logic        mac_lo_unused;

  assign mac_nar       = mac_d[51:25];
  assign mac_lo_unused = ^mac_d[24:0];
  assign cnt_inc       = count + 3'd1;
  assign ready         = (state == IDLE);
  assign valid         = (state == DONE);

  // Seed: 1/(1+(idx+0.5)/8) in Q2.25, idx taken from the top fraction bits.
  always_comb begin
    y0 = 27'd0;
    case (m[22:20])
      3'd0: y0 = 27'd31580641;
      3'd1: y0 = 27'd28256363;
      3'd2: y0 = 27'd25565281;
      3'd3: y0 = 27'd23342213;
      3'd4: y0 = 27'd21474836;
      3'd5: y0 = 27'd19884107;
      3'd6: y0 = 27'd18512790;
      3'd7: y0 = 27'd17318416;
      default: y0 = 27'd0;
    endcase
  end

  // Operands depend only on registered state so mac_d settles within the cycle.
  always_comb begin
    state_nxt = state;
    mac_a     = 27'd0;
    mac_b     = 27'd0;
    mac_c     = 27'd0;
    mac_op    = 1'b0;
    case (state)
      IDLE: if (start && !kill) state_nxt = m[23] ? ERR : DONE;
      ERR: begin
        mac_a     = ONE;
        mac_b     = mq;
        mac_c     = y;
        mac_op    = 1'b1;
        state_nxt = kill ? IDLE : UPD;
      end
      UPD: begin
        mac_a = y;
        mac_b = y;
        mac_c = e;
        if (kill)                     state_nxt = IDLE;
        else if (int'(cnt_inc) < ITER) state_nxt = ERR;
        else                          state_nxt = CORR;
      end
      CORR: begin
        mac_a     = ONE;
        mac_b     = mq;
        mac_c     = y;
        mac_op    = 1'b1;
        state_nxt = kill ? IDLE : DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      mq      <= 27'd0;
      y       <= 27'd0;
      e       <= 27'd0;
      count   <= 3'd0;
      recip   <= 27'd0;
      rem_neg <= 1'b0;
      inv     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start && !kill) begin
            if (m[23]) begin
              mq    <= {1'b0, m, 2'b00};
              y     <= y0;
              count <= 3'd0;
            end else begin
              inv     <= 1'b1;
              recip   <= 27'd0;
              rem_neg <= 1'b0;
            end
          end
        end
        ERR: if (!kill) e <= mac_nar;
        UPD: begin
          if (!kill) begin
            y     <= mac_nar;
            count <= cnt_inc;
          end
        end
        CORR: begin
          if (!kill) begin
            rem_neg <= mac_d[51];
            recip   <= y;
            inv     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_recip_seq.sv
// Bench for fp_recip_seq: three instances (ITER=3,1,4) each with a behavioural MAC.
module tb_fp_recip_seq;

  logic        clock = 1'b0;
  logic        reset, start, kill;
  logic [23:0] m;

  wire         ready_w [3];
  wire  [26:0] a_w     [3];
  wire  [26:0] b_w     [3];
  wire  [26:0] c_w     [3];
  wire         op_w    [3];
  wire  [51:0] d_w     [3];
  wire         valid_w [3];
  wire  [26:0] recip_w [3];
  wire         rneg_w  [3];
  wire         inv_w   [3];

  always #5 clock = ~clock;

  function automatic logic [51:0] mac_model(input logic [26:0] a, input logic [26:0] b,
                                            input logic [26:0] c, input logic op);
    longint av, bv, cv, d;
    av = longint'($signed(a));
    bv = longint'($signed(b));
    cv = longint'($signed(c));
    d  = (av <<< 25) + (op ? -(bv * cv) : (bv * cv));
    return d[51:0];
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int IT = (g == 0) ? 3 : ((g == 1) ? 1 : 4);
    fp_recip_seq #(.ITER(IT)) dut (
      .clock(clock), .reset(reset), .start(start), .m(m), .kill(kill),
      .ready(ready_w[g]), .mac_a(a_w[g]), .mac_b(b_w[g]), .mac_c(c_w[g]),
      .mac_op(op_w[g]), .mac_d(d_w[g]), .valid(valid_w[g]), .recip(recip_w[g]),
      .rem_neg(rneg_w[g]), .inv(inv_w[g])
    );
    assign d_w[g] = mac_model(a_w[g], b_w[g], c_w[g], op_w[g]);
  end

  typedef struct {
    logic [23:0] m;
    logic        inv;
    logic [26:0] rf;
  } vec_t;

  vec_t        tbl [10];
  int          total = 0;
  int          bad = 0;
  int          lat  [3];
  int          npls [3];
  logic [26:0] got_r [3];
  logic        got_n [3];
  logic        got_i [3];
  bit          ops_nz;

  task automatic check(input string nm, input bit ok, input longint act, input longint exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run(input logic [23:0] mv);
    for (int g = 0; g < 3; g++) begin
      lat[g]  = -1;
      npls[g] = 0;
    end
    ops_nz = 1'b0;
    @(negedge clock);
    start = 1'b1;
    m     = mv;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clock);
      start = 1'b0;
      for (int g = 0; g < 3; g++) begin
        if (valid_w[g]) begin
          npls[g]++;
          if (lat[g] < 0) lat[g] = k;
          got_r[g] = recip_w[g];
          got_n[g] = rneg_w[g];
          got_i[g] = inv_w[g];
        end
      end
      if (a_w[0] != 27'd0 || b_w[0] != 27'd0 || c_w[0] != 27'd0 || op_w[0]) ops_nz = 1'b1;
    end
  endtask

  task automatic verify(input logic [23:0] mv, input logic exp_inv, input logic [26:0] rf,
                        input string nm);
    for (int g = 0; g < 3; g++) begin
      int     it;
      int     exp_lat;
      longint tol, diff, res;
      it      = (g == 0) ? 3 : ((g == 1) ? 1 : 4);
      tol     = (g == 1) ? 64'sd262144 : 64'sd4;
      exp_lat = exp_inv ? 1 : 2 + 2 * it;
      check($sformatf("%s_lat_i%0d", nm, it), lat[g] == exp_lat, lat[g], exp_lat);
      check($sformatf("%s_pulses_i%0d", nm, it), npls[g] == 1, npls[g], 1);
      if (npls[g] == 0) continue;
      check($sformatf("%s_inv_i%0d", nm, it), got_i[g] == exp_inv, got_i[g], exp_inv);
      if (exp_inv) begin
        check($sformatf("%s_recip_i%0d", nm, it), got_r[g] == 27'd0, got_r[g], 0);
        check($sformatf("%s_remneg_i%0d", nm, it), got_n[g] == 1'b0, got_n[g], 0);
      end else begin
        diff = longint'(got_r[g]) - longint'(rf);
        if (diff < 0) diff = -diff;
        check($sformatf("%s_recip_i%0d", nm, it), diff <= tol, got_r[g], rf);
        res = (64'sd1 <<< 48) - longint'(mv) * longint'(got_r[g]);
        check($sformatf("%s_remneg_i%0d", nm, it), got_n[g] == (res < 0), got_n[g], res < 0);
      end
    end
    if (exp_inv) check({nm, "_ops_zero"}, !ops_nz, ops_nz, 0);
  endtask

  initial begin
    logic [26:0] held;
    logic [23:0] rm;
    int          np, lt;

    tbl[0] = '{24'h800000, 1'b0, 27'h2000000};
    tbl[1] = '{24'hFFFFFF, 1'b0, 27'h1000001};
    tbl[2] = '{24'hC00000, 1'b0, 27'h1555555};
    tbl[3] = '{24'hA00000, 1'b0, 27'h1999999};
    tbl[4] = '{24'hE00000, 1'b0, 27'h1249249};
    tbl[5] = '{24'h900000, 1'b0, 27'h1C71C71};
    tbl[6] = '{24'h800001, 1'b0, 27'h1FFFFFC};
    tbl[7] = '{24'h400000, 1'b1, 27'h0};
    tbl[8] = '{24'h000000, 1'b1, 27'h0};
    tbl[9] = '{24'hF00000, 1'b0, 27'h1111111};

    reset = 1'b1;
    start = 1'b0;
    kill  = 1'b0;
    m     = 24'h0;
    repeat (3) @(negedge clock);
    check("rst_ready", ready_w[0] == 1'b1, ready_w[0], 1);
    check("rst_valid", valid_w[0] == 1'b0, valid_w[0], 0);
    check("rst_recip", recip_w[0] == 27'd0, recip_w[0], 0);
    check("rst_flags", {rneg_w[0], inv_w[0]} == 2'b00, {rneg_w[0], inv_w[0]}, 0);
    check("rst_ops", {a_w[0], b_w[0], c_w[0], op_w[0]} == 82'd0, a_w[0], 0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run(tbl[i].m);
      verify(tbl[i].m, tbl[i].inv, tbl[i].rf, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 40; i++) begin
      rm = {1'b1, 23'($urandom)};
      run(rm);
      verify(rm, 1'b0, 27'((64'd1 << 48) / 64'(rm)), $sformatf("rnd%0d", i));
    end

    // Second start while busy is dropped.
    np = 0; lt = -1;
    @(negedge clock);
    start = 1'b1; m = 24'hC00000;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clock);
      if (valid_w[0]) begin np++; if (lt < 0) lt = k; end
      start = (k == 3);
      if (k == 3) m = 24'hA00000;
    end
    start = 1'b0;
    check("busy_pulses", np == 1, np, 1);
    check("busy_lat", lt == 8, lt, 8);
    check("busy_recip", recip_w[0] >= 27'h1555551 && recip_w[0] <= 27'h1555559,
          recip_w[0], 27'h1555555);
    held = recip_w[0];

    // Kill mid-iteration.
    np = 0;
    @(negedge clock);
    start = 1'b1; m = 24'hE00000;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clock);
      start = 1'b0;
      if (valid_w[0]) np++;
      if (k == 5) check("kill_ready", ready_w[0] == 1'b1, ready_w[0], 1);
      kill = (k == 4);
    end
    kill = 1'b0;
    check("kill_novalid", np == 0, np, 0);
    check("kill_hold", recip_w[0] == held, recip_w[0], held);

    // Kill together with start in IDLE.
    np = 0;
    @(negedge clock);
    start = 1'b1; kill = 1'b1; m = 24'h900000;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      start = 1'b0; kill = 1'b0;
      if (k == 1) check("killstart_ready", ready_w[0] == 1'b1, ready_w[0], 1);
      if (valid_w[0]) np++;
    end
    check("killstart_novalid", np == 0, np, 0);

    run(24'hE00000);
    verify(24'hE00000, 1'b0, 27'h1249249, "after_kill");

    // Reset while in UPD.
    @(negedge clock);
    start = 1'b1; m = 24'h900000;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      start = 1'b0;
      if (k == 3) begin
        check("mid_rst_ready", ready_w[0] == 1'b1, ready_w[0], 1);
        check("mid_rst_valid", valid_w[0] == 1'b0, valid_w[0], 0);
        check("mid_rst_recip", recip_w[0] == 27'd0, recip_w[0], 0);
        check("mid_rst_ops", {a_w[0], b_w[0], c_w[0], op_w[0]} == 82'd0, a_w[0], 0);
      end
      reset = (k == 2);
    end
    reset = 1'b0;

    run(24'hA00000);
    verify(24'hA00000, 1'b0, 27'h1999999, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
